pipe_if_fetch: RTL
==================

# pipe_if_fetch

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined CPU. It sits directly downstream of the PC register. It takes the current `pc`, fetches the instruction from a variable-latency instruction memory over a req/ack handshake, and loads the instruction and `pc+4` into the IF/ID register for the ID stage. It honours the hazard-unit stall (`wpcir`) and a flush. It also reports `if_stall` so the PC holds while a fetch is still in flight.

## Interface
- No parameters (data/address width fixed at 32).
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `pc` in 32: current PC from the PC register.
- `wpcir` in 1: 1 = ID may accept a new instruction; 0 = hold IF/ID (bubble upstream).
- `flush` in 1: squash; IF/ID loads a bubble and any in-flight fetch is discarded.
- `imem_req` out 1: fetch request; held high until `imem_ack`.
- `imem_addr` out 32: fetch address (= `pc` while `imem_req`).
- `imem_ack` in 1: memory response; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: fetched instruction.
- `if_stall` out 1: combinational; 1 = no instruction deliverable this cycle. The PC write enable is `wpcir & ~if_stall`, or `flush` for a redirect.
- `dinst` out 32: IF/ID instruction.
- `dpc4` out 32: IF/ID `pc+4`.
- `dvalid` out 1: IF/ID holds a real instruction (0 = bubble, `dinst`=0).

## Operation
- States: IDLE, REQ, HOLD, DROP. Reset state is IDLE.
- IDLE: `imem_req`=0, acks ignored. Next state is REQ.
- REQ: `imem_req`=1, `imem_addr`=`pc`. Only one request is ever outstanding.
  - `avail` = `imem_ack`.
  - On `imem_ack & wpcir & ~flush`: load IF/ID with {`imem_rdata`, `pc+4`, 1} and stay in REQ. The next cycle requests the new `pc`.
  - On `imem_ack & ~wpcir & ~flush`: capture `imem_rdata` and `pc+4` into the hold buffer. Go to HOLD.
  - On no ack: IF/ID unchanged if `wpcir`=0. If `wpcir`=1, load a bubble (ID consumed its instruction and nothing new is ready).
- HOLD: `imem_req`=0, `avail`=1. When `wpcir`=1, load IF/ID from the hold buffer and go to REQ. Otherwise stay in HOLD.
- DROP: `imem_req`=1 with the latched old address. Wait for ack, discard `imem_rdata`, then go to REQ (new `pc`).
- `if_stall` = `~avail`. `if_stall` is 1 in IDLE and DROP.
- `flush` (priority over `wpcir` and ack):
  - IF/ID loads a bubble (`dinst`=0, `dpc4`=0, `dvalid`=0).
  - REQ without ack goes to DROP. REQ with ack drops the data and stays in REQ.
  - HOLD clears the buffer and goes to REQ.
- `pc+4` is computed modulo 2^32: 0xFFFFFFFC gives 0x00000000.
- While in REQ and DROP, `imem_addr` is latched at request start. It stays stable until ack, even if `pc` changes.

## Timing
- Async reset clears IF/ID (`dinst`=0, `dpc4`=0, `dvalid`=0), the hold buffer, and the state to IDLE.
  - `imem_req`=0 and `if_stall`=1 during and right after reset.
  - An ack arriving after reset is ignored in IDLE.
  - Reset asserted mid-fetch abandons the request immediately.
- First request is issued in the cycle after reset deassertion.
- Memory may ack in the same cycle `imem_req` rises (zero-wait). That gives 1 instruction/cycle, with IF/ID updated at the edge ending the ack cycle.
- N-wait memory: `if_stall`=1 for N cycles per instruction, and the instruction lands in IF/ID at the ack edge.
- `wpcir`=0 at ack costs no memory re-access. The instruction issues from HOLD on the first edge with `wpcir`=1.

## Test plan
- Zero-wait memory, `pc` 0x00→0x04→0x08, `wpcir`=1:
  - `dinst` follows `imem_rdata` each cycle.
  - `dpc4` = 0x04, 0x08, 0x0C.
  - `dvalid`=1, `if_stall`=0.
- 2-wait memory (ack 2 cycles after req), `pc`=0x10:
  - `if_stall`=1 for 2 cycles, `dvalid`=0 meanwhile.
  - `dinst` = rdata and `dpc4`=0x14 at the ack edge.
- Ack with `wpcir`=0 for 3 cycles:
  - State is HOLD, `imem_req`=0, IF/ID unchanged.
  - On `wpcir`=1, `dinst` = captured word. Exactly one memory access occurs.
- `flush` during a 3-wait fetch at 0x20, `pc` redirected to 0x80:
  - IF/ID bubble and DROP state.
  - Ack for 0x20 is discarded, then a request to 0x80 is issued with `imem_addr`=0x80.
- `pc`=0xFFFFFFFC: `dpc4`=0x00000000.
- `resetn` low mid-fetch with a late ack:
  - All IF/ID outputs are 0 and `imem_req`=0 immediately.
  - The ack is ignored, and the first new request follows deassertion by 1 cycle.

Source files
------------

// File: rtl/pipe_if_fetch.sv
// pipe_if_fetch
//   Instruction-fetch stage plus IF/ID pipeline register. Fetches the word at
//   `pc` over a req/ack handshake with a variable-latency instruction memory
//   and loads {instruction, pc+4, valid} into IF/ID for the decode stage.
//
// Ports
//   clock, resetn      : rising-edge clock, asynchronous active-low reset
//   pc                 : current PC from the PC register
//   wpcir              : 1 = ID accepts a new instruction, 0 = hold IF/ID
//   flush              : squash IF/ID and discard any in-flight fetch
//   imem_req/imem_addr : fetch request (held until ack) and its address
//   imem_ack/imem_rdata: memory response, data valid with ack
//   if_stall           : combinational, 1 = no instruction deliverable now
//   dinst/dpc4/dvalid  : IF/ID instruction, pc+4 and valid (0 = bubble)
module pipe_if_fetch (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] pc,
  input  logic        wpcir,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_stall,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic        inflight_q, inflight_d;   // a request is outstanding past its first cycle
  logic [31:0] addr_q, addr_d;           // address latched at request start
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] dinst_q, dinst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        dvalid_q, dvalid_d;
  logic        avail;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_pc4;

  always_comb begin
    // First cycle of a request presents pc directly so zero-wait memory can
    // ack immediately; afterwards the latched address is held until ack.
    fetch_addr  = inflight_q ? addr_q : pc;
    fetch_pc4   = fetch_addr + 32'd4;

    state_d     = state_q;
    inflight_d  = 1'b0;
    addr_d      = addr_q;
    hold_inst_d = hold_inst_q;
    hold_pc4_d  = hold_pc4_q;
    dinst_d     = dinst_q;
    dpc4_d      = dpc4_q;
    dvalid_d    = dvalid_q;
    imem_req    = 1'b0;
    imem_addr   = fetch_addr;
    avail       = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        avail    = imem_ack;
        if (imem_ack) begin
          if (!flush) begin
            if (wpcir) begin
              dinst_d  = imem_rdata;
              dpc4_d   = fetch_pc4;
              dvalid_d = 1'b1;
            end else begin
              hold_inst_d = imem_rdata;
              hold_pc4_d  = fetch_pc4;
              state_d     = HOLD;
            end
          end
        end else begin
          inflight_d = 1'b1;
          addr_d     = fetch_addr;
          if (flush) state_d = DROP;
        end
      end
      HOLD: begin
        avail = 1'b1;
        if (flush) begin
          hold_inst_d = '0;
          hold_pc4_d  = '0;
          state_d     = REQ;
        end else if (wpcir) begin
          dinst_d     = hold_inst_q;
          dpc4_d      = hold_pc4_q;
          dvalid_d    = 1'b1;
          hold_inst_d = '0;
          hold_pc4_d  = '0;
          state_d     = REQ;
        end
      end
      DROP: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = REQ;
        else          inflight_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Bubble: on flush always; otherwise when ID drains and nothing is ready.
    if (flush || (!avail && wpcir)) begin
      dinst_d  = '0;
      dpc4_d   = '0;
      dvalid_d = 1'b0;
    end

    if_stall = ~avail;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      addr_q      <= '0;
      hold_inst_q <= '0;
      hold_pc4_q  <= '0;
      dinst_q     <= '0;
      dpc4_q      <= '0;
      dvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      addr_q      <= addr_d;
      hold_inst_q <= hold_inst_d;
      hold_pc4_q  <= hold_pc4_d;
      dinst_q     <= dinst_d;
      dpc4_q      <= dpc4_d;
      dvalid_q    <= dvalid_d;
    end
  end

  assign dinst  = dinst_q;
  assign dpc4   = dpc4_q;
  assign dvalid = dvalid_q;

endmodule
